// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state types and the size-to-byte-count helper for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} size_t;
  typedef enum logic [1:0] {IDLE, ACCESS, ACCESS2, RESPOND} state_t;
  function automatic logic [3:0] size_bytes(size_t s);
    return 4'd1 << s;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and Wishbone-classic signals; slave = LSU side, master = core/bus side
interface load_store_unit_if import lsu_pkg::*; #(parameter int XLEN = 32);
  localparam int LANES = XLEN / 8;
  logic req_valid, req_ready, req_write, req_unsigned;
  size_t req_size;
  logic [XLEN-1:0] req_address, req_store_data;
  logic resp_valid, resp_misaligned_exception, resp_bus_error;
  logic [XLEN-1:0] resp_load_data;
  logic cyc_o, stb_o, we_o, ack_i, err_i;
  logic [XLEN-1:0] adr_o, dat_o, dat_i;
  logic [LANES-1:0] sel_o;
  modport slave (
    input req_valid, req_write, req_size, req_unsigned, req_address, req_store_data, dat_i, ack_i, err_i,
    output req_ready, resp_valid, resp_load_data, resp_misaligned_exception, resp_bus_error,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_store_data, dat_i, ack_i, err_i,
    input req_ready, resp_valid, resp_load_data, resp_misaligned_exception, resp_bus_error,
    input cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
  );
endinterface

// File: rtl/lsu_lane_shifter.sv
// lsu_lane_shifter: byte-lane select, store steering and load extract/extend over a two-beat lane window
module lsu_lane_shifter import lsu_pkg::*; #(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OB = $clog2(LANES)
) (
  input  logic [OB-1:0]      offset,
  input  size_t              size,
  input  logic               is_unsigned,
  input  logic [XLEN-1:0]    store_data,
  input  logic [2*XLEN-1:0]  window,
  output logic [2*LANES-1:0] sel,
  output logic [2*XLEN-1:0]  store_wide,
  output logic [XLEN-1:0]    load_data
);
  logic [2*XLEN-1:0] shifted;
  logic [6:0] nbits;
  logic sign;
  always_comb begin
    sel = (((2*LANES)'(1) << size_bytes(size)) - (2*LANES)'(1)) << offset;
    store_wide = {{XLEN{1'b0}}, store_data} << {offset, 3'b000};
    shifted = window >> {offset, 3'b000};
    nbits = {size_bytes(size), 3'b000};
    sign = !is_unsigned && (size == BYTE ? shifted[7] : size == HALF ? shifted[15] :
                            size == WORD ? shifted[31] : shifted[63]);
    load_data = '0;
    for (int i = 0; i < XLEN; i++) load_data[i] = (i < nbits) ? shifted[i] : sign;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle load/store unit to Wishbone-classic; ports clk, reset, bus (load_store_unit_if.slave); LSU_MISALIGNED_SPLIT_EN enables two-beat boundary-crossing accesses
module load_store_unit import lsu_pkg::*; #(parameter int XLEN = 32) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  localparam int LANES = XLEN / 8;
  localparam int OB = $clog2(LANES);
  state_t state, state_n;
  size_t size_q;
  logic write_q, uns_q, split_q, mis_q, err_q;
  logic [XLEN-1:0] addr_q, sdata_q, buf_q, data_q, floor_adr, ld;
  logic [2*LANES-1:0] sel_w;
  logic [2*XLEN-1:0] store_w, window;
  logic dbl, fault, split;
  assign dbl = (XLEN == 32) && (bus.req_size == DOUBLE);
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic cross;
  assign cross = (int'(bus.req_address[OB-1:0]) + int'(size_bytes(bus.req_size))) > LANES;
  assign fault = dbl;
  assign split = cross && !dbl;
`else
  logic nat_mis;
  assign nat_mis = |(bus.req_address[2:0] & 3'(size_bytes(bus.req_size) - 4'd1));
  assign fault = nat_mis || dbl;
  assign split = 1'b0;
`endif
  // second beat places the upper lane half above the buffered first beat
  assign window = state == ACCESS2 ? {bus.dat_i, buf_q} : {{XLEN{1'b0}}, bus.dat_i};
  assign floor_adr = {addr_q[XLEN-1:OB], OB'(0)};
  lsu_lane_shifter #(.XLEN(XLEN)) shifter (
    .offset(addr_q[OB-1:0]), .size(size_q), .is_unsigned(uns_q), .store_data(sdata_q),
    .window(window), .sel(sel_w), .store_wide(store_w), .load_data(ld)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.req_valid ? (fault ? RESPOND : ACCESS) : IDLE)
            : state == ACCESS ? (bus.err_i ? RESPOND : bus.ack_i ? (split_q ? ACCESS2 : RESPOND) : ACCESS)
            : state == ACCESS2 ? (bus.err_i || bus.ack_i ? RESPOND : ACCESS2) : IDLE;
    bus.req_ready = state == IDLE;
    bus.cyc_o = state == ACCESS || state == ACCESS2;
    bus.stb_o = bus.cyc_o;
    bus.we_o = bus.cyc_o && write_q;
    bus.adr_o = state == ACCESS ? floor_adr : state == ACCESS2 ? floor_adr + XLEN'(LANES) : '0;
    bus.sel_o = state == ACCESS ? sel_w[LANES-1:0] : state == ACCESS2 ? sel_w[2*LANES-1:LANES] : '0;
    bus.dat_o = !write_q ? '0 : state == ACCESS ? store_w[XLEN-1:0] : state == ACCESS2 ? store_w[2*XLEN-1:XLEN] : '0;
    bus.resp_valid = state == RESPOND;
    bus.resp_load_data = state == RESPOND ? data_q : '0;
    bus.resp_misaligned_exception = state == RESPOND && mis_q;
    bus.resp_bus_error = state == RESPOND && err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {write_q, uns_q, split_q, mis_q, err_q} <= '0;
      size_q <= BYTE;
      {addr_q, sdata_q, buf_q, data_q} <= '0;
    end else begin
      if (state == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        size_q <= bus.req_size;
        uns_q <= bus.req_unsigned;
        addr_q <= bus.req_address;
        sdata_q <= bus.req_store_data;
        split_q <= split;
        mis_q <= fault;
        err_q <= 1'b0;
        data_q <= '0;
      end
      if (state == ACCESS && bus.ack_i && !bus.err_i) buf_q <= bus.dat_i;
      if ((state == ACCESS || state == ACCESS2) && bus.err_i) err_q <= 1'b1;
      if (bus.ack_i && !bus.err_i && !write_q && (state == ACCESS2 || (state == ACCESS && !split_q)))
        data_q <= ld;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit at XLEN=32
module tb_load_store_unit;
  import lsu_pkg::*;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  load_store_unit_if #(.XLEN(32)) bus();
  load_store_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {logic [31:0] data; logic mis; logic err;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic w, input size_t sz, input logic u, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] ed, input logic em, input logic ee);
    @(negedge clk);
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_address = a; bus.req_store_data = sd;
    q.push_back('{ed, em, ee});
    @(posedge clk);
    #1 bus.req_valid = 0; bus.req_address = 32'hDEAD_BEE1; bus.req_store_data = '1; bus.req_size = BYTE;
    @(negedge clk);
  endtask

  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ed,
                      input logic ew, input int waits, input logic [31:0] rd, input logic a, input logic e);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, "_cyc"}, bus.cyc_o, 1);
      chk({tag, "_stb"}, bus.stb_o, 1);
      chk({tag, "_we"}, bus.we_o, ew);
      chk({tag, "_adr"}, bus.adr_o, ea);
      chk({tag, "_sel"}, bus.sel_o, es);
      chk({tag, "_dat"}, bus.dat_o, ed);
      chk({tag, "_noresp"}, bus.resp_valid, 0);
      if (i == waits) begin
        bus.ack_i = a; bus.err_i = e; bus.dat_i = rd;
      end else @(negedge clk);
    end
    @(posedge clk);
    #1 bus.ack_i = 0; bus.err_i = 0; bus.dat_i = 32'h5A5A_5A5A;
    @(negedge clk);
  endtask

  task automatic resp(input string tag);
    exp_t e;
    chk({tag, "_resp_valid"}, bus.resp_valid, 1);
    chk({tag, "_resp_cyc"}, bus.cyc_o, 0);
    chk({tag, "_resp_ready"}, bus.req_ready, 0);
    chk({tag, "_sb_depth"}, 64'(q.size()), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, "_data"}, bus.resp_load_data, e.data);
      chk({tag, "_mis"}, bus.resp_misaligned_exception, e.mis);
      chk({tag, "_err"}, bus.resp_bus_error, e.err);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, bus.resp_valid, 0);
    chk({tag, "_ready_back"}, bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = BYTE; bus.req_unsigned = 0;
    bus.req_address = 0; bus.req_store_data = 0; bus.ack_i = 0; bus.err_i = 0; bus.dat_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_valid", bus.resp_valid, 0);
    chk("rst_cyc", bus.cyc_o, 0);
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_we", bus.we_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    chk("rst_sel", bus.sel_o, 0);
    chk("rst_data", bus.resp_load_data, 0);
    chk("rst_mis", bus.resp_misaligned_exception, 0);
    chk("rst_err", bus.resp_bus_error, 0);
    reset = 0;

    start(0, WORD, 0, 32'h100, 0, 32'h8000_00F0, 0, 0);
    beat("lw", 32'h100, 4'b1111, 0, 0, 2, 32'h8000_00F0, 1, 0);
    resp("lw");

    start(0, BYTE, 0, 32'h103, 0, 32'hFFFF_FF80, 0, 0);
    beat("lb", 32'h100, 4'b1000, 0, 0, 0, 32'h8000_0000, 1, 0);
    resp("lb");

    start(0, BYTE, 1, 32'h103, 0, 32'h0000_0080, 0, 0);
    beat("lbu", 32'h100, 4'b1000, 0, 0, 1, 32'h8000_0000, 1, 0);
    resp("lbu");

    start(1, HALF, 0, 32'h202, 32'h1234_ABCD, 0, 0, 0);
    beat("sh", 32'h200, 4'b1100, 32'hABCD_0000, 1, 1, 0, 1, 0);
    resp("sh");

    start(0, HALF, 0, 32'h206, 0, 32'hFFFF_FEDC, 0, 0);
    beat("lh", 32'h204, 4'b1100, 0, 0, 0, 32'hFEDC_1234, 1, 0);
    resp("lh");

    start(0, HALF, 1, 32'h204, 0, 32'h0000_1234, 0, 0);
    beat("lhu", 32'h204, 4'b0011, 0, 0, 0, 32'hFEDC_1234, 1, 0);
    resp("lhu");

    start(1, WORD, 0, 32'h300, 32'hCAFE_F00D, 0, 0, 1);
    beat("sw_err", 32'h300, 4'b1111, 32'hCAFE_F00D, 1, 1, 0, 1, 1);
    resp("sw_err");

`ifdef LSU_MISALIGNED_SPLIT_EN
    start(0, WORD, 0, 32'h101, 0, 32'h4433_2211, 0, 0);
    beat("split_b1", 32'h100, 4'b1110, 0, 0, 1, 32'h3322_1100, 1, 0);
    beat("split_b2", 32'h104, 4'b0001, 0, 0, 0, 32'h7766_5544, 1, 0);
    resp("split_lw");

    start(1, WORD, 0, 32'h103, 32'h1122_3344, 0, 0, 1);
    beat("split_sw_b1", 32'h100, 4'b1000, 32'h4400_0000, 1, 0, 0, 0, 1);
    resp("split_sw_err");

    start(0, HALF, 0, 32'h101, 0, 32'hFFFF_BBAA, 0, 0);
    beat("lh_odd", 32'h100, 4'b0110, 0, 0, 0, 32'h00BB_AA00, 1, 0);
    resp("lh_odd");
`else
    start(0, WORD, 0, 32'h101, 0, 0, 1, 0);
    resp("lw_mis");

    start(1, HALF, 0, 32'h203, 32'hFFFF_FFFF, 0, 1, 0);
    resp("sh_mis");
`endif

    start(0, DOUBLE, 0, 32'h108, 0, 0, 1, 0);
    resp("ld32");

    @(negedge clk);
    bus.ack_i = 1; bus.err_i = 1;
    @(posedge clk);
    #1 bus.ack_i = 0; bus.err_i = 0;
    @(negedge clk);
    chk("idle_ack_valid", bus.resp_valid, 0);
    chk("idle_ack_cyc", bus.cyc_o, 0);
    chk("idle_ack_ready", bus.req_ready, 1);

    start(0, WORD, 0, 32'h400, 0, 0, 0, 0);
    chk("mid_stb", bus.stb_o, 1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    q.delete();
    @(negedge clk);
    chk("mid_rst_cyc", bus.cyc_o, 0);
    chk("mid_rst_stb", bus.stb_o, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_valid", bus.resp_valid, 0);
    bus.ack_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_valid", bus.resp_valid, 0);
      chk("post_rst_cyc", bus.cyc_o, 0);
    end
    bus.ack_i = 0;

    start(0, WORD, 0, 32'h500, 0, 32'h1357_9BDF, 0, 0);
    beat("recover", 32'h500, 4'b1111, 0, 0, 0, 32'h1357_9BDF, 1, 0);
    resp("recover");

    chk("sb_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multicycle, parametrised memory access unit between the RV core data path and a Wishbone-classic data bus.
- Accepts one load/store request at a time and steers byte lanes. Generates sel_o.
- Sign/zero-extends load data to XLEN. Reports misaligned-access and bus-error status per request.
- Generalises the existing 32-bit load decoder / store encoder to XLEN=32/64, adds a bus handshake, and optionally splits boundary-crossing accesses into two beats.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- LANES, XLEN/8, byte lanes per bus beat; derived, not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  lsu_pkg size: BYTE=0, HALF=1, WORD=2, DOUBLE=3
- req_unsigned  in  1  load zero-extends when 1
- req_address  in  XLEN  byte address
- req_store_data  in  XLEN  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_load_data  out  XLEN  extended load result; 0 for stores and faults
- resp_misaligned_exception  out  1  valid with resp_valid
- resp_bus_error  out  1  valid with resp_valid
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  Wishbone write enable
- adr_o  out  XLEN  beat address, low log2(LANES) bits zero
- dat_o  out  XLEN  lane-steered store data; unused lanes 0
- sel_o  out  LANES  byte-lane select
- dat_i  in  XLEN  read data
- ack_i  in  1  beat acknowledge
- err_i  in  1  beat error

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values:
  - req_ready=1.
  - resp_valid, cyc_o, stb_o and we_o all 0.
  - adr_o, dat_o, sel_o, resp_load_data and both status flags all 0.
- States (lsu_pkg::state_t):
  - IDLE, ACCESS, ACCESS2, RESPOND.
  - req_ready=1 only in IDLE.
  - Requests are accepted on req_valid && req_ready. Request fields are registered at that edge.
- Misalignment:
  - Natural misalignment: the address is not a multiple of 2^size.
  - req_size=DOUBLE with XLEN=32 is always treated as misaligned.
- IDLE, accepted request:
  - Faulting request (per Optional Feature): go to RESPOND with no bus activity.
  - Otherwise: go to ACCESS with cyc_o=stb_o=1 and we_o=req_write from the next cycle.
- ACCESS:
  - Outputs are held until ack_i or err_i.
  - err_i has priority over a simultaneous ack_i.
  - On err_i: go to RESPOND with bus_error=1.
  - On ack_i of a final beat: go to RESPOND.
  - On ack_i of the first beat of a split access: go to ACCESS2. cyc_o/stb_o stay high; adr_o += LANES and sel_o/dat_o switch to the second-beat lanes.
- ACCESS2:
  - Same handshake as ACCESS.
  - On ack_i: the load buffer is merged, then go to RESPOND.
  - On err_i: the merged data is discarded and bus_error=1.
- RESPOND:
  - resp_valid=1 for exactly one cycle, cyc_o=stb_o=0.
  - Next state is IDLE.
- Latency:
  - Request accepted at edge 0, stb_o high from cycle 1.
  - ack_i sampled at edge k gives resp_valid in cycle k+1 and req_ready=1 in cycle k+2.
  - Misaligned fault without split: resp_valid in cycle 1.
- Lane rule: offset = address mod LANES.
  - Store: dat_o = req_store_data << 8*offset; sel_o = ((1<<2^size)-1) << offset.
  - Load: result = dat_i >> 8*offset, truncated to 2^size bytes, then sign- or zero-extended to XLEN.
- ack_i/err_i outside ACCESS/ACCESS2 are ignored.
- Reset mid-operation: the next edge forces IDLE and drops cyc_o/stb_o. No resp_valid is produced and the split beat is abandoned.
- While in IDLE, req_* changes have no effect until acceptance.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Undefined:
  - Any natural misalignment faults: resp_misaligned_exception=1 and no bus cycle.
- Defined, offset+2^size <= LANES (no boundary crossing):
  - Single beat.
- Defined, boundary crossing:
  - Two beats. Beat 1 uses the aligned floor address with lanes offset..LANES-1. Beat 2 uses floor+LANES with the low lanes.
  - Load bytes are concatenated in address order before extension.
- DOUBLE on XLEN=32 still faults in both configurations.

Decomposition:
- lsu_pkg: size_t enum, state_t enum, size-to-byte-count function.
- Sub-module lsu_lane_shifter: combinational offset/size to sel, store shift and load extract/extend. Instantiated once, shared across beats.

Test Plan:
- XLEN=32, word load 0x100, ack_i after 2 wait cycles, dat_i=0x800000F0 -> adr_o=0x100, sel_o=1111; resp_valid one cycle after ack; load_data=0x800000F0.
- Byte load 0x103, dat_i=0x80000000: signed -> sel_o=1000, load_data=0xFFFFFF80; unsigned -> 0x00000080.
- Half store 0x202, data 0x1234ABCD -> we_o=1, sel_o=1100, dat_o=0xABCD0000.
- Word load 0x101, macro off -> no cyc_o, resp_valid cycle 1, misaligned=1, load_data=0.
- Word load 0x101, macro on, with dat_i=0x33221100 then 0x77665544:
  - beat 1: adr 0x100, sel 1110, cyc_o continuous;
  - beat 2: adr 0x104, sel 0001;
  - result: load_data=0x44332211.
- Split store with err_i on beat 1 -> no beat 2, resp bus_error=1. Separately, reset during ACCESS -> next cycle cyc_o=stb_o=0, req_ready=1, no resp_valid.
